// File: rtl/spi_slave_frontend_if.sv
// Bundles the SPI pins and the RAM-side word/response handshake of
// spi_slave_frontend. The slave modport is the frontend's view; the
// master modport is the view of whatever drives the pins and models the RAM.
interface spi_slave_frontend_if #(
  parameter int MEM_WIDTH = 8
);
  logic                 SS_n;
  logic                 MOSI;
  logic                 MISO;
  logic [MEM_WIDTH+1:0] rx_data;
  logic                 rx_valid;
  logic [MEM_WIDTH-1:0] tx_data;
  logic                 tx_valid;

  modport slave (
    input  SS_n, MOSI, tx_data, tx_valid,
    output MISO, rx_data, rx_valid
  );

  modport master (
    output SS_n, MOSI, tx_data, tx_valid,
    input  MISO, rx_data, rx_valid
  );
endinterface

// File: rtl/spi_slave_frontend.sv
// SPI slave frontend: deserialises MOSI frames (select bit + control/payload
// word, MSB first) into one-cycle rx_valid strobes for the RAM, and shifts the
// RAM's read response back out on MISO. One bit per clk edge while SS_n is low.
// CNT_WIDTH must satisfy 2**CNT_WIDTH > MEM_WIDTH+2.
module spi_slave_frontend #(
  parameter int MEM_WIDTH = 8,
  parameter int CNT_WIDTH = 4
) (
  input logic                 clk,
  input logic                 rst,
  spi_slave_frontend_if.slave bus
);

  localparam int                   WORD_W  = MEM_WIDTH + 2;
  localparam logic [CNT_WIDTH-1:0] LAST_RX = CNT_WIDTH'(WORD_W - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_TX = CNT_WIDTH'(MEM_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    CHK_CMD,
    WRITE,
    READ_ADD,
    READ_DATA
  } state_t;

  state_t                 state;
  // Holds the first WORD_W-1 bits; the last bit is taken straight from MOSI.
  logic [WORD_W-2:0]      shift_reg;
  logic [CNT_WIDTH-1:0]   counter;
  logic                   rd_addr_received;
  logic                   word_done;
  logic                   tx_busy;
  logic                   tx_done;
  logic [MEM_WIDTH-1:0]   tx_shift;
  logic                   miso_reg;
  logic [WORD_W-1:0]      rx_data_reg;
  logic                   rx_valid_reg;

  assign bus.MISO     = miso_reg;
  assign bus.rx_data  = rx_data_reg;
  assign bus.rx_valid = rx_valid_reg;

  // Frame FSM: word reception, read-response serialisation, SS_n abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state            <= IDLE;
      shift_reg        <= '0;
      counter          <= '0;
      rd_addr_received <= 1'b0;
      word_done        <= 1'b0;
      tx_busy          <= 1'b0;
      tx_done          <= 1'b0;
      tx_shift         <= '0;
      miso_reg         <= 1'b0;
      rx_data_reg      <= '0;
      rx_valid_reg     <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (state != IDLE && bus.SS_n) begin
        // Frame abort or normal end: partial word dropped, rd flag untouched.
        state     <= IDLE;
        miso_reg  <= 1'b0;
        counter   <= '0;
        word_done <= 1'b0;
        tx_busy   <= 1'b0;
        tx_done   <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            miso_reg  <= 1'b0;
            counter   <= '0;
            word_done <= 1'b0;
            tx_busy   <= 1'b0;
            tx_done   <= 1'b0;
            if (!bus.SS_n) begin
              state <= CHK_CMD;
            end
          end
          CHK_CMD: begin
            counter   <= '0;
            word_done <= 1'b0;
            if (!bus.MOSI) begin
              state <= WRITE;
            end else if (rd_addr_received) begin
              state <= READ_DATA;
            end else begin
              state <= READ_ADD;
            end
          end
          WRITE, READ_ADD, READ_DATA: begin
            if (!word_done) begin
              shift_reg <= {shift_reg[WORD_W-3:0], bus.MOSI};
              counter   <= counter + 1'b1;
              if (counter == LAST_RX) begin
                rx_data_reg  <= {shift_reg, bus.MOSI};
                rx_valid_reg <= 1'b1;
                word_done    <= 1'b1;
                if (state == READ_ADD) begin
                  rd_addr_received <= 1'b1;
                end
              end
            end else if (state == READ_DATA && !tx_done) begin
              // Counter is reused as the MISO bit index once the word is in.
              if (!tx_busy) begin
                if (bus.tx_valid) begin
                  miso_reg <= bus.tx_data[MEM_WIDTH-1];
                  tx_shift <= {bus.tx_data[MEM_WIDTH-2:0], 1'b0};
                  counter  <= '0;
                  tx_busy  <= 1'b1;
                end
              end else if (counter == LAST_TX) begin
                miso_reg         <= 1'b0;
                tx_busy          <= 1'b0;
                tx_done          <= 1'b1;
                rd_addr_received <= 1'b0;
              end else begin
                miso_reg <= tx_shift[MEM_WIDTH-1];
                tx_shift <= tx_shift << 1;
                counter  <= counter + 1'b1;
              end
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spi_slave_frontend.sv
// Self-checking bench for spi_slave_frontend: directed scenarios plus a
// randomized frame sequence checked against a frame-level behavioural model.
module tb_spi_slave_frontend;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  spi_slave_frontend_if #(.MEM_WIDTH(8)) bus ();

  spi_slave_frontend #(
    .MEM_WIDTH(8),
    .CNT_WIDTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  // Frame-level model state
  bit         m_rd_addr  = 1'b0;
  logic [9:0] m_last_rx  = '0;
  int         exp_pulses;
  logic [63:0] exp_miso;

  // RAM stub fed from observed rx words
  logic [7:0] stub_mem [256];
  logic [7:0] stub_wr_addr = '0;
  logic [7:0] stub_rd_addr = '0;

  // Observations from the last frame
  int          obs_pulses;
  int          obs_pulse_k;
  logic [9:0]  obs_rx;
  logic [9:0]  obs_rx_end;
  logic [63:0] obs_miso;
  logic        obs_rst_miso, obs_rst_rxv, obs_rst_rda;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Drives one frame: edge 0 enters CHK_CMD, edge 1 samples select, edges
  // 2..nbits+1 sample word bits; SS_n rises afterwards (after the response
  // window for full frames). rst_k >= 0 asserts reset right after edge rst_k.
  task automatic run_frame(input bit sel, input logic [9:0] word, input int nbits,
                           input bit tx_en, input logic [7:0] tx_byte,
                           input int d, input int rst_k);
    bit full       = (nbits >= 10);
    int k_low      = full ? (23 + d) : (nbits + 2);
    int tx_k       = 12 + d;
    bit data_frame = sel && m_rd_addr;
    exp_miso   = '0;
    exp_pulses = full ? 1 : 0;
    if (full && data_frame && tx_en) begin
      for (int j = 0; j < 8; j++) exp_miso[tx_k + j] = tx_byte[7 - j];
    end
    obs_pulses  = 0;
    obs_pulse_k = -1;
    obs_rx      = '0;
    obs_miso    = '0;
    for (int k = 0; k <= k_low; k++) begin
      @(negedge clk);
      bus.SS_n = (k < k_low) ? 1'b0 : 1'b1;
      if (k <= 1) bus.MOSI = sel;
      else if (k - 2 < nbits) bus.MOSI = word[11 - k];
      else bus.MOSI = 1'($urandom);
      if (tx_en) begin
        bus.tx_valid = (k == tx_k);
        bus.tx_data  = (k == tx_k) ? tx_byte : 8'($urandom);
      end else begin
        bus.tx_valid = 1'($urandom);
        bus.tx_data  = 8'($urandom);
      end
      @(posedge clk);
      #1;
      obs_miso[k] = bus.MISO;
      if (bus.rx_valid) begin
        obs_pulses++;
        obs_pulse_k = k;
        obs_rx      = bus.rx_data;
        case (bus.rx_data[9:8])
          2'b00: stub_wr_addr = bus.rx_data[7:0];
          2'b01: stub_mem[stub_wr_addr] = bus.rx_data[7:0];
          2'b10: stub_rd_addr = bus.rx_data[7:0];
          default: ;
        endcase
      end
      obs_rx_end = bus.rx_data;
      if (k == rst_k) begin
        rst = 1'b1;
        #1;
        obs_rst_miso = bus.MISO;
        obs_rst_rxv  = bus.rx_valid;
        obs_rst_rda  = dut.rd_addr_received;
        break;
      end
    end
    if (rst_k >= 0) begin
      @(negedge clk);
      bus.SS_n     = 1'b1;
      bus.tx_valid = 1'b0;
      rst          = 1'b0;
      for (int k = rst_k + 1; k < 64; k++) exp_miso[k] = 1'b0;
      m_rd_addr = 1'b0;
      m_last_rx = '0;
    end else if (full) begin
      m_last_rx = word;
      if (sel && !m_rd_addr) m_rd_addr = 1'b1;
      else if (data_frame && tx_en) m_rd_addr = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      bus.SS_n     = 1'b1;
      bus.MOSI     = 1'($urandom);
      bus.tx_valid = 1'($urandom);
      bus.tx_data  = 8'($urandom);
    end
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.SS_n = 1'b1; bus.MOSI = 1'b0; bus.tx_valid = 1'b0; bus.tx_data = '0;
    #12;
    tests_run++;
    if (bus.rx_valid !== 1'b0) begin
      tests_failed++; $display("FAIL reset rx_valid: got %b want 0", bus.rx_valid);
    end
    tests_run++;
    if (bus.MISO !== 1'b0) begin
      tests_failed++; $display("FAIL reset MISO: got %b want 0", bus.MISO);
    end
    tests_run++;
    if (bus.rx_data !== 10'h000) begin
      tests_failed++; $display("FAIL reset rx_data: got %h want 000", bus.rx_data);
    end
    tests_run++;
    if (dut.rd_addr_received !== 1'b0) begin
      tests_failed++; $display("FAIL reset rd_addr_received: got %b want 0", dut.rd_addr_received);
    end
    @(negedge clk);
    rst = 1'b0;
    idle(2);
  endtask

  task automatic test_write_addr();
    run_frame(1'b0, 10'h005, 10, 1'b0, 8'h00, 0, -1);
    tests_run++;
    if (obs_pulses !== 1) begin
      tests_failed++; $display("FAIL write_addr pulses: got %0d want 1", obs_pulses);
    end
    tests_run++;
    if (obs_pulse_k !== 11) begin
      tests_failed++; $display("FAIL write_addr latency: got %0d want 11", obs_pulse_k);
    end
    tests_run++;
    if (obs_rx !== 10'h005) begin
      tests_failed++; $display("FAIL write_addr rx_data: got %h want 005", obs_rx);
    end
    idle(2);
  endtask

  task automatic test_write_data();
    run_frame(1'b0, 10'h1AA, 10, 1'b0, 8'h00, 0, -1);
    tests_run++;
    if (obs_pulses !== 1) begin
      tests_failed++; $display("FAIL write_data pulses: got %0d want 1", obs_pulses);
    end
    tests_run++;
    if (obs_rx !== 10'h1AA) begin
      tests_failed++; $display("FAIL write_data rx_data: got %h want 1aa", obs_rx);
    end
    tests_run++;
    if (stub_mem[5] !== 8'hAA) begin
      tests_failed++; $display("FAIL write_data ram[5]: got %h want aa", stub_mem[5]);
    end
    idle(2);
  endtask

  task automatic test_read();
    logic [63:0] want;
    logic [7:0]  aa = 8'hAA;
    run_frame(1'b1, 10'h205, 10, 1'b0, 8'h00, 0, -1);
    tests_run++;
    if (obs_rx !== 10'h205 || obs_pulses !== 1) begin
      tests_failed++; $display("FAIL read_addr rx_data: got %h (%0d pulses) want 205 (1 pulse)", obs_rx, obs_pulses);
    end
    tests_run++;
    if (dut.rd_addr_received !== 1'b1) begin
      tests_failed++; $display("FAIL read_addr rd_addr_received: got %b want 1", dut.rd_addr_received);
    end
    tests_run++;
    if (obs_miso !== 64'h0) begin
      tests_failed++; $display("FAIL read_addr MISO quiet: got %h want 0", obs_miso);
    end
    idle(2);
    run_frame(1'b1, 10'h3C3, 10, 1'b1, stub_mem[stub_rd_addr], 1, -1);
    want = '0;
    for (int j = 0; j < 8; j++) want[13 + j] = aa[7 - j];
    tests_run++;
    if (obs_pulses !== 1 || obs_rx !== 10'h3C3) begin
      tests_failed++; $display("FAIL read_data rx: got %h (%0d pulses) want 3c3 (1 pulse)", obs_rx, obs_pulses);
    end
    tests_run++;
    if (obs_miso !== want) begin
      tests_failed++; $display("FAIL read_data MISO trace: got %h want %h", obs_miso, want);
    end
    tests_run++;
    if (dut.rd_addr_received !== 1'b0) begin
      tests_failed++; $display("FAIL read_data rd_addr_received: got %b want 0", dut.rd_addr_received);
    end
    idle(2);
  endtask

  task automatic test_abort();
    logic [9:0] prev = m_last_rx;
    run_frame(1'b0, 10'h0F3, 4, 1'b0, 8'h00, 0, -1);
    tests_run++;
    if (obs_pulses !== 0) begin
      tests_failed++; $display("FAIL abort pulses: got %0d want 0", obs_pulses);
    end
    tests_run++;
    if (obs_rx_end !== prev) begin
      tests_failed++; $display("FAIL abort rx_data held: got %h want %h", obs_rx_end, prev);
    end
    idle(1);
    run_frame(1'b0, 10'h0F3, 10, 1'b0, 8'h00, 0, -1);
    tests_run++;
    if (obs_pulses !== 1 || obs_rx !== 10'h0F3) begin
      tests_failed++; $display("FAIL abort recovery: got %h (%0d pulses) want 0f3 (1 pulse)", obs_rx, obs_pulses);
    end
    idle(2);
  endtask

  task automatic test_reset_mid_read();
    logic [7:0] b = 8'($urandom) | 8'h10;
    run_frame(1'b1, 10'h211, 10, 1'b0, 8'h00, 0, -1);
    idle(1);
    run_frame(1'b1, 10'h300, 10, 1'b1, b, 2, 17);
    tests_run++;
    if (obs_miso !== exp_miso) begin
      tests_failed++; $display("FAIL rst_mid MISO before reset: got %h want %h", obs_miso, exp_miso);
    end
    tests_run++;
    if (obs_rst_miso !== 1'b0 || obs_rst_rxv !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid outputs: got MISO=%b rx_valid=%b want 0 0", obs_rst_miso, obs_rst_rxv);
    end
    tests_run++;
    if (obs_rst_rda !== 1'b0) begin
      tests_failed++; $display("FAIL rst_mid rd_addr_received: got %b want 0", obs_rst_rda);
    end
    idle(2);
    // After reset a read frame must be taken as an address frame again.
    run_frame(1'b1, 10'h277, 10, 1'b1, 8'hFF, 1, -1);
    tests_run++;
    if (obs_miso !== 64'h0 || dut.rd_addr_received !== 1'b1) begin
      tests_failed++; $display("FAIL rst_mid next frame: got MISO=%h rd=%b want 0 1", obs_miso, dut.rd_addr_received);
    end
    idle(1);
    run_frame(1'b1, 10'h300, 10, 1'b1, 8'h5A, 0, -1);
    idle(2);
  endtask

  task automatic test_back_to_back();
    int total = 0;
    run_frame(1'b0, 10'h012, 10, 1'b0, 8'h00, 0, -1);
    total += obs_pulses;
    tests_run++;
    if (obs_rx !== 10'h012) begin
      tests_failed++; $display("FAIL b2b first word: got %h want 012", obs_rx);
    end
    run_frame(1'b0, 10'h16C, 10, 1'b0, 8'h00, 0, -1);
    total += obs_pulses;
    tests_run++;
    if (obs_rx !== 10'h16C || obs_pulse_k !== 11) begin
      tests_failed++; $display("FAIL b2b second word: got %h at %0d want 16c at 11", obs_rx, obs_pulse_k);
    end
    tests_run++;
    if (total !== 2) begin
      tests_failed++; $display("FAIL b2b pulse count: got %0d want 2", total);
    end
    idle(2);
  endtask

  task automatic test_random();
    for (int n = 0; n < 40; n++) begin
      bit         sel   = 1'($urandom);
      logic [9:0] word  = 10'($urandom);
      int         nbits = ($urandom_range(0, 9) < 7) ? 10 : $urandom_range(0, 9);
      int         d     = $urandom_range(0, 5);
      logic [7:0] b     = 8'($urandom);
      run_frame(sel, word, nbits, 1'b1, b, d, -1);
      tests_run++;
      if (obs_pulses !== exp_pulses || (exp_pulses == 1 && obs_pulse_k !== 11)) begin
        tests_failed++; $display("FAIL random[%0d] rx_valid: got %0d pulses at %0d want %0d at 11", n, obs_pulses, obs_pulse_k, exp_pulses);
      end
      tests_run++;
      if (obs_rx_end !== m_last_rx) begin
        tests_failed++; $display("FAIL random[%0d] rx_data: got %h want %h", n, obs_rx_end, m_last_rx);
      end
      tests_run++;
      if (obs_miso !== exp_miso) begin
        tests_failed++; $display("FAIL random[%0d] MISO trace: got %h want %h", n, obs_miso, exp_miso);
      end
      tests_run++;
      if (dut.rd_addr_received !== m_rd_addr) begin
        tests_failed++; $display("FAIL random[%0d] rd_addr_received: got %b want %b", n, dut.rd_addr_received, m_rd_addr);
      end
      idle($urandom_range(0, 2));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) stub_mem[i] = '0;
    test_reset();
    test_write_addr();
    test_write_data();
    test_read();
    test_abort();
    test_reset_mid_read();
    test_back_to_back();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/spi_slave_frontend.md
Name: spi_slave_frontend

Overview:
- Serial-side counterpart of the SPI RAM: deserialises MOSI frames into rx_data/rx_valid words for the RAM.
- Serialises the RAM's read response (tx_data/tx_valid) back out on MISO.
- Sits between the SPI pins and the RAM inside the SPI wrapper.
- SPI bit clock equals the system clock: one MOSI/MISO bit per clk rising edge while SS_n is low.

Parameters:
- MEM_WIDTH, 8, RAM data/address width; rx word is MEM_WIDTH+2 bits.
- CNT_WIDTH, 4, bit-counter width; must satisfy 2^CNT_WIDTH > MEM_WIDTH+2.

Ports:
- clk  in  1  system/SPI clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- SS_n  in  1  active-low slave select; frame boundary.
- MOSI  in  1  serial data in, MSB first.
- MISO  out  1  serial data out, MSB first.
- rx_data  out  MEM_WIDTH+2  received word: [MEM_WIDTH+1:MEM_WIDTH] control, [MEM_WIDTH-1:0] payload.
- rx_valid  out  1  one-cycle strobe; rx_data is valid in the same cycle.
- tx_data  in  MEM_WIDTH  read data from the RAM.
- tx_valid  in  1  strobe qualifying tx_data.

Behaviour:
- Reset (async, rst=1): state=IDLE, MISO=0, rx_data=0, rx_valid=0, shift register=0, counter=0, rd_addr_received=0.
- Control encoding: WR_ADDR=00, WR_DATA=01, RD_ADDR=10, RD_DATA=11.
- Frame = 1 select bit + MEM_WIDTH+2 word bits; RD_DATA frames are followed by MEM_WIDTH MISO bits.
- FSM states: IDLE, CHK_CMD, WRITE, READ_ADD, READ_DATA.
- IDLE:
  - SS_n=0 -> CHK_CMD next cycle; otherwise stay.
  - MISO=0, rx_valid=0.
- CHK_CMD (samples select bit on MOSI):
  - MOSI=0 -> WRITE.
  - MOSI=1 and rd_addr_received=0 -> READ_ADD.
  - MOSI=1 and rd_addr_received=1 -> READ_DATA.
  - Counter cleared.
- WRITE / READ_ADD / READ_DATA receive phase:
  - Shift MOSI into the shift register LSB side for MEM_WIDTH+2 cycles.
  - On the cycle the last bit is sampled: rx_data <= complete word, rx_valid=1 for exactly that cycle.
  - Control bits are forwarded unchecked; the RAM decodes them.
- After the word completes in WRITE/READ_ADD: hold state, ignore further MOSI, no further rx_valid until SS_n rises.
- READ_ADD completion sets rd_addr_received=1.
- READ_DATA response phase:
  - After rx_valid, wait for tx_valid (RAM responds 1 cycle later); wait is unbounded.
  - tx_valid=1 latches tx_data.
  - MISO drives bit MEM_WIDTH-1 on the next cycle, then one bit per cycle down to bit 0 (MEM_WIDTH cycles).
  - After bit 0: MISO=0, rd_addr_received cleared.
  - tx_valid outside the READ_DATA wait window is ignored.
- SS_n=1 in any non-IDLE state:
  - IDLE next cycle; partial word discarded; no rx_valid.
  - MISO=0; counter cleared.
  - rd_addr_received unchanged unless its frame completed.
- SS_n low in the same cycle the FSM returns to IDLE: handled as a new frame start (CHK_CMD next).
- rx_data holds its last value between strobes.
- rx_valid never asserts in IDLE or CHK_CMD.
- Async reset mid-frame: immediate return to reset values; the frame is lost.

Test Plan:
- Write address: SS_n=0, MOSI 0 then 00_0000_0101 -> rx_data=10'h005 with a single rx_valid pulse 11 cycles after CHK_CMD entry; SS_n=1 -> IDLE.
- Write data: select 0, word 01_1010_1010 -> rx_data=10'h1AA, one rx_valid; RAM model stores 0xAA at address 5.
- Read address then read data:
  - Frame 1: select 1, word 10_0000_0101 -> rx_data=10'h205, rd_addr_received=1.
  - Frame 2: select 1, word 11_xxxx_xxxx -> rx_valid, then tx_valid with tx_data=0xAA -> MISO shifts 1,0,1,0,1,0,1,0 on consecutive cycles; rd_addr_received=0 afterwards.
- Abort: SS_n raised after 4 word bits -> IDLE next cycle, no rx_valid, rx_data unchanged; next full frame decodes correctly.
- Reset mid-READ_DATA: rst pulsed during MISO shifting -> MISO=0, rx_valid=0, state IDLE, rd_addr_received=0 immediately (asynchronous).
- Back-to-back frames: SS_n high for exactly 1 cycle between two write frames -> both words delivered, exactly two rx_valid pulses.
